// File: rtl/tagged_reg_jump_core.sv
// Issue-stage core: tagged register alias table, fixed-priority CDB mux and a
// combinational jump/branch resolver that sees CDB-forwarded operands.
module tagged_reg_jump_core #(
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      FU_regWrite,
   input  logic [4:0]                raddr_A,
   input  logic [4:0]                raddr_B,
   input  logic [4:0]                waddr,
   input  logic [TAG_W-1:0]          w_tag,
   input  logic                      restore,
   input  logic [31*TAG_W-1:0]       restore_tags_bus,
   input  logic                      ALU_cdb_request,
   input  logic                      mul_cdb_request,
   input  logic                      div_cdb_request,
   input  logic                      ls_cdb_request,
   input  logic [TAG_W+DATA_W-1:0]   ALU_cdb_in,
   input  logic [TAG_W+DATA_W-1:0]   mul_cdb_in,
   input  logic [TAG_W+DATA_W-1:0]   div_cdb_in,
   input  logic [TAG_W+DATA_W-1:0]   ls_cdb_in,
   input  logic                      branch_issue,
   input  logic                      ujump_issue,
   input  logic [3:0]                JUMP_op,
   input  logic [DATA_W-1:0]         imm,
   input  logic [DATA_W-1:0]         PC,
   output logic [TAG_W+DATA_W-1:0]   rdata_A,
   output logic [TAG_W+DATA_W-1:0]   rdata_B,
   output logic [TAG_W+DATA_W:0]     cdb,
   output logic [31*TAG_W-1:0]       all_tags_bus,
   output logic [DATA_W-1:0]         PC_jump,
   output logic [DATA_W-1:0]         PCp4,
   output logic                      to_jump,
   output logic                      jump_stall
);

   localparam int unsigned PL_W = TAG_W + DATA_W;

   // Entry 0 is never written after reset, so x0 reads as {0, 0}.
   logic [TAG_W-1:0]  r_tag  [32];
   logic [DATA_W-1:0] r_data [32];

   logic [PL_W:0]       w_cdb;
   logic                w_cdb_valid;
   logic [TAG_W-1:0]    w_cdb_tag;
   logic [DATA_W-1:0]   w_cdb_data;
   logic [PL_W-1:0]     w_rdata_a;
   logic [PL_W-1:0]     w_rdata_b;
   logic [DATA_W-1:0]   w_pcp4;
   logic                w_ujump_wb;
   logic                w_stall;
   logic                w_cond;
   logic [TAG_W-1:0]    w_tag_a;
   logic [TAG_W-1:0]    w_tag_b;
   logic [DATA_W-1:0]   w_op_a;
   logic [DATA_W-1:0]   w_op_b;
   logic [DATA_W-1:0]   w_jalr_sum;

   always_comb begin
      w_cdb = '0;
      if (!rst) begin
         if (ALU_cdb_request)      w_cdb = {1'b1, ALU_cdb_in};
         else if (mul_cdb_request) w_cdb = {1'b1, mul_cdb_in};
         else if (div_cdb_request) w_cdb = {1'b1, div_cdb_in};
         else if (ls_cdb_request)  w_cdb = {1'b1, ls_cdb_in};
      end
   end

   assign w_cdb_valid = w_cdb[PL_W];
   assign w_cdb_tag   = w_cdb[PL_W-1:DATA_W];
   assign w_cdb_data  = w_cdb[DATA_W-1:0];
   assign cdb         = w_cdb;

   always_comb begin
      w_rdata_a = {r_tag[raddr_A], r_data[raddr_A]};
      if (r_tag[raddr_A] != '0 && w_cdb_valid && r_tag[raddr_A] == w_cdb_tag) begin
         w_rdata_a = {{TAG_W{1'b0}}, w_cdb_data};
      end
      w_rdata_b = {r_tag[raddr_B], r_data[raddr_B]};
      if (r_tag[raddr_B] != '0 && w_cdb_valid && r_tag[raddr_B] == w_cdb_tag) begin
         w_rdata_b = {{TAG_W{1'b0}}, w_cdb_data};
      end
   end

   assign rdata_A = w_rdata_a;
   assign rdata_B = w_rdata_b;

   always_comb begin
      all_tags_bus = '0;
      for (int i = 1; i < 32; i++) begin
         all_tags_bus[(i-1)*TAG_W +: TAG_W] = r_tag[i];
      end
   end

   // Later assignments win: link write over CDB capture, issue tag over both,
   // restore over every tag update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (w_cdb_valid && r_tag[i] != '0 && r_tag[i] == w_cdb_tag) begin
               r_data[i] <= w_cdb_data;
               r_tag[i]  <= '0;
            end
            if (w_ujump_wb && waddr == 5'(i)) begin
               r_data[i] <= w_pcp4;
               r_tag[i]  <= '0;
            end
            if (FU_regWrite && !w_ujump_wb && waddr == 5'(i)) begin
               r_tag[i] <= w_tag;
            end
            if (restore) begin
               r_tag[i] <= restore_tags_bus[(i-1)*TAG_W +: TAG_W];
            end
         end
      end
   end

   assign w_tag_a = w_rdata_a[PL_W-1:DATA_W];
   assign w_tag_b = w_rdata_b[PL_W-1:DATA_W];
   assign w_op_a  = w_rdata_a[DATA_W-1:0];
   assign w_op_b  = w_rdata_b[DATA_W-1:0];

   assign w_pcp4     = PC + DATA_W'(4);
   assign w_jalr_sum = w_op_a + imm;

   always_comb begin
      w_stall = 1'b0;
      if (ujump_issue) begin
         w_stall = JUMP_op[3] && (w_tag_a != '0);
      end else if (branch_issue) begin
         w_stall = (w_tag_a != '0) || (w_tag_b != '0);
      end
   end

   always_comb begin
      w_cond = 1'b0;
      case (JUMP_op[2:0])
         3'b000:  w_cond = (w_op_a == w_op_b);
         3'b001:  w_cond = (w_op_a != w_op_b);
         3'b100:  w_cond = ($signed(w_op_a) <  $signed(w_op_b));
         3'b101:  w_cond = ($signed(w_op_a) >= $signed(w_op_b));
         3'b110:  w_cond = (w_op_a <  w_op_b);
         3'b111:  w_cond = (w_op_a >= w_op_b);
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      PC_jump = PC + imm;
      if (ujump_issue && JUMP_op[3]) begin
         PC_jump = {w_jalr_sum[DATA_W-1:1], 1'b0};
      end
   end

   assign w_ujump_wb = ujump_issue && !w_stall;
   assign jump_stall = w_stall;
   assign to_jump    = !w_stall && (ujump_issue || (branch_issue && w_cond));
   assign PCp4       = w_pcp4;

endmodule

// File: tb/tb_tagged_reg_jump_core.sv
// Scoreboard bench for tagged_reg_jump_core: expectations are queued as each
// cycle's stimulus is driven and drained once the outputs have settled.
module tb_tagged_reg_jump_core;

   logic          clk;
   logic          rst;
   logic          FU_regWrite;
   logic [4:0]    raddr_A, raddr_B, waddr;
   logic [7:0]    w_tag;
   logic          restore;
   logic [247:0]  restore_tags_bus;
   logic          ALU_cdb_request, mul_cdb_request, div_cdb_request, ls_cdb_request;
   logic [39:0]   ALU_cdb_in, mul_cdb_in, div_cdb_in, ls_cdb_in;
   logic          branch_issue, ujump_issue;
   logic [3:0]    JUMP_op;
   logic [31:0]   imm, PC;
   logic [39:0]   rdata_A, rdata_B;
   logic [40:0]   cdb;
   logic [247:0]  all_tags_bus;
   logic [31:0]   PC_jump, PCp4;
   logic          to_jump, jump_stall;

   tagged_reg_jump_core #(.TAG_W(8), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .FU_regWrite(FU_regWrite),
      .raddr_A(raddr_A), .raddr_B(raddr_B), .waddr(waddr), .w_tag(w_tag),
      .restore(restore), .restore_tags_bus(restore_tags_bus),
      .ALU_cdb_request(ALU_cdb_request), .mul_cdb_request(mul_cdb_request),
      .div_cdb_request(div_cdb_request), .ls_cdb_request(ls_cdb_request),
      .ALU_cdb_in(ALU_cdb_in), .mul_cdb_in(mul_cdb_in),
      .div_cdb_in(div_cdb_in), .ls_cdb_in(ls_cdb_in),
      .branch_issue(branch_issue), .ujump_issue(ujump_issue), .JUMP_op(JUMP_op),
      .imm(imm), .PC(PC), .rdata_A(rdata_A), .rdata_B(rdata_B), .cdb(cdb),
      .all_tags_bus(all_tags_bus), .PC_jump(PC_jump), .PCp4(PCp4),
      .to_jump(to_jump), .jump_stall(jump_stall)
   );

   localparam int SRA = 0, SRB = 1, SCDB = 2, STAGS = 3, SPCJ = 4, SPC4 = 5, STJ = 6,
                  SST = 7;

   typedef struct {
      string        name;
      int           sel;
      logic [255:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [255:0] got,
                           input logic [255:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [255:0] obs(input int sel);
      case (sel)
         SRA:     return 256'(rdata_A);
         SRB:     return 256'(rdata_B);
         SCDB:    return 256'(cdb);
         STAGS:   return 256'(all_tags_bus);
         SPCJ:    return 256'(PC_jump);
         SPC4:    return 256'(PCp4);
         STJ:     return 256'(to_jump);
         default: return 256'(jump_stall);
      endcase
   endfunction

   task automatic expect_val(input string name, input int sel, input logic [255:0] v);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic begin_cyc();
      @(negedge clk);
      FU_regWrite = 0; waddr = 0; w_tag = 0; restore = 0; restore_tags_bus = '0;
      ALU_cdb_request = 0; mul_cdb_request = 0; div_cdb_request = 0; ls_cdb_request = 0;
      ALU_cdb_in = '0; mul_cdb_in = '0; div_cdb_in = '0; ls_cdb_in = '0;
      branch_issue = 0; ujump_issue = 0; JUMP_op = 0; imm = 0; PC = 0;
      raddr_A = 0; raddr_B = 0;
   endtask

   task automatic end_cyc();
      exp_t e;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.name, obs(e.sel), e.val);
      end
   endtask

   localparam logic [247:0] Snap = 248'h55_0000_0000;

   initial begin
      rst = 1'b1;
      begin_cyc();
      ALU_cdb_request = 1; ALU_cdb_in = 40'h82_0000_0048;
      expect_val("cdb_in_reset", SCDB, '0);
      end_cyc();
      begin_cyc();
      rst = 1'b0;
      raddr_A = 1;
      expect_val("reset_x1", SRA, '0);
      expect_val("reset_tags", STAGS, '0);
      expect_val("idle_cdb", SCDB, '0);
      end_cyc();

      // Issue and tagging
      begin_cyc(); FU_regWrite = 1; waddr = 1; w_tag = 8'h81; raddr_A = 1; end_cyc();
      begin_cyc(); FU_regWrite = 1; waddr = 1; w_tag = 8'h82; raddr_A = 1;
      expect_val("tag81", SRA, {8'h81, 32'h0}); end_cyc();
      begin_cyc(); FU_regWrite = 1; waddr = 2; w_tag = 8'h84; raddr_A = 1;
      expect_val("tag82", SRA, {8'h82, 32'h0}); end_cyc();
      begin_cyc(); raddr_B = 2;
      expect_val("tag84", SRB, {8'h84, 32'h0});
      expect_val("tags_8482", STAGS, 256'h8482); end_cyc();

      // JALR: stall, then forward from CDB
      begin_cyc(); ujump_issue = 1; JUMP_op = 4'b1000; PC = 32'hC0; imm = 32'hA6;
      raddr_A = 1; waddr = 2;
      expect_val("jalr_stall", SST, 1);
      expect_val("jalr_stall_nojump", STJ, 0);
      expect_val("pcp4", SPC4, 256'hC4); end_cyc();
      begin_cyc(); ujump_issue = 1; JUMP_op = 4'b1000; PC = 32'hC0; imm = 32'hA6;
      raddr_A = 1; waddr = 2; ALU_cdb_request = 1; ALU_cdb_in = 40'h82_0000_0048;
      expect_val("fwd_cdb", SCDB, {1'b1, 8'h82, 32'h48});
      expect_val("fwd_rdata", SRA, 256'h48);
      expect_val("fwd_nostall", SST, 0);
      expect_val("fwd_jump", STJ, 1);
      expect_val("jalr_target", SPCJ, 256'hEE); end_cyc();
      begin_cyc(); raddr_A = 1; raddr_B = 2;
      expect_val("x1_captured", SRA, 256'h48);
      expect_val("x2_link", SRB, 256'hC4);
      expect_val("tags_clear", STAGS, '0); end_cyc();

      // CDB priority
      begin_cyc(); ALU_cdb_request = 1; ALU_cdb_in = 40'h11_AAAA_AAAA;
      ls_cdb_request = 1; ls_cdb_in = 40'h22_5555_5555;
      expect_val("prio_alu", SCDB, {1'b1, 40'h11_AAAA_AAAA}); end_cyc();
      begin_cyc(); mul_cdb_request = 1; mul_cdb_in = 40'h33_0000_0003;
      div_cdb_request = 1; div_cdb_in = 40'h44_0000_0004;
      ls_cdb_request = 1; ls_cdb_in = 40'h22_5555_5555;
      expect_val("prio_mul", SCDB, {1'b1, 40'h33_0000_0003}); end_cyc();
      begin_cyc(); div_cdb_request = 1; div_cdb_in = 40'h44_0000_0004;
      ls_cdb_request = 1; ls_cdb_in = 40'h22_5555_5555;
      expect_val("prio_div", SCDB, {1'b1, 40'h44_0000_0004}); end_cyc();
      begin_cyc(); ls_cdb_request = 1; ls_cdb_in = 40'h22_5555_5555;
      expect_val("prio_ls", SCDB, {1'b1, 40'h22_5555_5555}); end_cyc();

      // Branches and JAL link writes
      begin_cyc(); branch_issue = 1; JUMP_op = 4'b0000; PC = 32'h100; imm = 32'h20;
      raddr_A = 1; raddr_B = 1;
      expect_val("beq_taken", STJ, 1);
      expect_val("beq_target", SPCJ, 256'h120); end_cyc();
      begin_cyc(); branch_issue = 1; JUMP_op = 4'b0001; raddr_A = 1; raddr_B = 1;
      expect_val("bne_not_taken", STJ, 0); end_cyc();
      begin_cyc(); ujump_issue = 1; JUMP_op = 4'b0000; PC = 32'hFFFF_FFFB; imm = 32'h5;
      waddr = 3;
      expect_val("jal_wrap_target", SPCJ, '0);
      expect_val("jal_taken", STJ, 1); end_cyc();
      begin_cyc(); ujump_issue = 1; JUMP_op = 4'b0000; PC = 32'hFFFF_FFFD; waddr = 4;
      raddr_A = 3;
      expect_val("x3_link", SRA, 256'hFFFF_FFFF); end_cyc();
      begin_cyc(); branch_issue = 1; JUMP_op = 4'b0100; PC = 32'h200; imm = 32'hFFFF_FFF8;
      raddr_A = 3; raddr_B = 4;
      expect_val("x4_link", SRB, 256'h1);
      expect_val("blt_taken", STJ, 1);
      expect_val("blt_target", SPCJ, 256'h1F8); end_cyc();
      begin_cyc(); branch_issue = 1; JUMP_op = 4'b0110; raddr_A = 3; raddr_B = 4;
      expect_val("bltu_not_taken", STJ, 0); end_cyc();
      begin_cyc(); branch_issue = 1; JUMP_op = 4'b0111; raddr_A = 3; raddr_B = 4;
      expect_val("bgeu_taken", STJ, 1); end_cyc();
      begin_cyc(); branch_issue = 1; JUMP_op = 4'b0010; raddr_A = 1; raddr_B = 1;
      expect_val("f3_010_never", STJ, 0); end_cyc();

      // Restore
      begin_cyc(); FU_regWrite = 1; waddr = 5; w_tag = 8'h55; end_cyc();
      begin_cyc(); FU_regWrite = 1; waddr = 1; w_tag = 8'h91;
      expect_val("snapshot", STAGS, 256'(Snap)); end_cyc();
      begin_cyc(); FU_regWrite = 1; waddr = 2; w_tag = 8'h92;
      branch_issue = 1; JUMP_op = 4'b0000; raddr_A = 3; raddr_B = 1;
      expect_val("branch_rs2_stall", SST, 1);
      expect_val("branch_stall_nojump", STJ, 0); end_cyc();
      begin_cyc(); ujump_issue = 1; branch_issue = 1; JUMP_op = 4'b0000;
      PC = 32'h40; imm = 32'h10; raddr_A = 1; raddr_B = 1; waddr = 0;
      expect_val("jal_prec_nostall", SST, 0);
      expect_val("jal_prec_jump", STJ, 1);
      expect_val("jal_prec_target", SPCJ, 256'h50); end_cyc();
      begin_cyc(); restore = 1; restore_tags_bus = Snap;
      FU_regWrite = 1; waddr = 6; w_tag = 8'h66; raddr_A = 0;
      expect_val("x0_link_ignored", SRA, '0);
      expect_val("retagged", STAGS, 256'h55_0000_9291); end_cyc();
      begin_cyc(); FU_regWrite = 1; waddr = 0; w_tag = 8'h77;
      expect_val("restored", STAGS, 256'(Snap)); end_cyc();

      // Issue tag wins over same-cycle CDB capture; data still written
      begin_cyc(); raddr_A = 0; raddr_B = 5;
      ALU_cdb_request = 1; ALU_cdb_in = 40'h55_0000_1234;
      FU_regWrite = 1; waddr = 5; w_tag = 8'h5A;
      expect_val("x0_tag_ignored", SRA, '0);
      expect_val("bypass_x5", SRB, 256'h1234); end_cyc();
      begin_cyc(); raddr_A = 5;
      expect_val("capture_and_retag", SRA, {8'h5A, 32'h1234}); end_cyc();

      // Reset mid-operation
      begin_cyc(); rst = 1; ALU_cdb_request = 1; ALU_cdb_in = 40'h5A_0000_0001;
      expect_val("cdb_reset_mid", SCDB, '0); end_cyc();
      begin_cyc(); rst = 0; raddr_A = 5; raddr_B = 3;
      expect_val("reset_x5", SRA, '0);
      expect_val("reset_x3", SRB, '0);
      expect_val("reset_all_tags", STAGS, '0); end_cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
